lcd_ctrl: RTL and testbench
===========================

Name: lcd_ctrl

Overview:
- HD44780-compatible character-LCD interface controller. Sits directly downstream of the core's LSU LCD output path.
- Accepts byte writes (command or data) over a valid/ready handshake and generates the bus protocol on the LCD pins: setup, enable pulse, hold, and execution-time wait.
- Frees firmware from bit-banging EN timing through the memory-mapped LCD register.

Parameters:
- T_SETUP_CYC, 2, cycles RS/DATA are stable before EN rises (min 1)
- T_EN_CYC, 25, cycles EN is held high (min 1)
- T_HOLD_CYC, 2, cycles RS/DATA are held after EN falls (min 1)
- T_EXEC_SHORT_CYC, 2000, execution wait for normal commands and data (min 1)
- T_EXEC_LONG_CYC, 80000, execution wait for clear/home commands (min 1)
- T_PWRUP_CYC, 2000000, power-up wait; used only with LCD_INIT_SEQ_EN

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wr_vld  in  1  write request
- i_wr_rs  in  1  0 = command, 1 = data
- i_wr_data  in  8  byte to write
- o_wr_rdy  out  1  controller idle; can accept a write
- i_lcd_on  in  1  power/backlight request, passed through registered
- o_init_done  out  1  init sequence complete
- o_lcd_data  out  8  LCD DB[7:0]
- o_lcd_rs  out  1  LCD RS
- o_lcd_rw  out  1  LCD RW; constant 0 (write-only)
- o_lcd_en  out  1  LCD EN
- o_lcd_on  out  1  LCD power, registered copy of i_lcd_on

Behaviour:
- Reset (async, i_rst_n=0):
  - o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=8'h00, o_lcd_on=0.
  - o_wr_rdy=0 while in reset.
  - FSM goes to IDLE, or to PWRUP with the macro. All counters are cleared.
  - Reset mid-transfer drops EN immediately; the in-flight byte is discarded.
- FSM states: IDLE, SETUP, EN_HI, HOLD, WAIT, plus PWRUP and INIT_ISSUE under the macro.
- Handshake:
  - o_wr_rdy=1 only in IDLE.
  - Accept occurs on a clock edge where i_wr_vld and o_wr_rdy are both 1. At that edge rs/data are latched into o_lcd_rs/o_lcd_data and the FSM moves to SETUP.
  - i_wr_vld held while not ready is ignored; no queuing.
- Timing, counted from the accept edge:
  - SETUP lasts T_SETUP_CYC cycles with en=0.
  - EN_HI lasts exactly T_EN_CYC cycles with en=1.
  - HOLD lasts T_HOLD_CYC cycles with en=0.
  - WAIT lasts T_exec cycles.
  - o_wr_rdy rises exactly T_SETUP_CYC+T_EN_CYC+T_HOLD_CYC+T_exec cycles after the accept edge.
- T_exec selection: T_EXEC_LONG_CYC when rs=0 and data[7:2]==0 and data!=0 (clear 0x01, home 0x02/0x03). Otherwise T_EXEC_SHORT_CYC.
- o_lcd_data and o_lcd_rs hold the last written value in IDLE. EN never glitches: it is a registered output.
- One down-counter serves all timed states. Its width is $clog2 of the largest parameter plus 1. Parameter values of 0 are treated as 1.
- o_lcd_on is i_lcd_on registered one cycle, independent of the FSM.

Optional Feature:
- LCD_INIT_SEQ_EN defined:
  - After reset the FSM enters PWRUP and waits T_PWRUP_CYC cycles.
  - INIT_ISSUE then sends 0x38, 0x0C, 0x01, 0x06 in order, all rs=0. Each uses the normal SETUP/EN_HI/HOLD/WAIT timing; 0x01 uses the long wait.
  - o_init_done rises when the last WAIT ends, together with o_wr_rdy. o_wr_rdy=0 until then.
  - Reset value of o_init_done = 0.
- Macro undefined:
  - No PWRUP/INIT states. After reset the FSM enters IDLE.
  - o_init_done is constant 1, including its reset value.

Decomposition:
- Package lcd_pkg holds:
  - the FSM state enum
  - constants LCD_CMD_FUNC_SET=8'h38, LCD_CMD_DISP_ON=8'h0C, LCD_CMD_CLEAR=8'h01, LCD_CMD_ENTRY=8'h06
  - the init-sequence length (4)
- One sub-module, lcd_timer: loadable down-counter with a done flag, used for every timed state.

Test Plan:
Bench parameters: T_SETUP=2, T_EN=3, T_HOLD=1, SHORT=5, LONG=20, PWRUP=10; macro off unless stated.
- Data write: rs=1, data=0x41 accepted at edge 0 -> en high during cycles 2-4 only, data=0x41 stable throughout, o_wr_rdy high again at edge 11.
- Clear command: rs=0, data=0x01 -> long wait; o_wr_rdy returns at edge 26. A following command 0x0C returns at edge 11 after its accept.
- Back-pressure: i_wr_vld held high with 0x42 then 0x43 across a busy period -> exactly one accept per IDLE visit, two EN pulses, no lost byte.
- Reset asserted during EN_HI -> en=0 and rdy=0 immediately. After release, rdy=1 next cycle and data=0x00.
- Macro on, reset release -> 10 idle cycles, then four EN pulses carrying 0x38, 0x0C, 0x01, 0x06. o_init_done and o_wr_rdy rise together after the final wait; pre-init i_wr_vld is ignored.
- i_lcd_on toggles 0->1 -> o_lcd_on follows one cycle later, including while busy.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller.
// Holds the FSM state enum, init command bytes and small timing helpers.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_WAIT
`ifdef LCD_INIT_SEQ_EN
    ,
    S_PWRUP,
    S_INIT_ISSUE
`endif
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
  localparam int unsigned LCD_INIT_LEN    = 4;

  // A zero cycle count would underflow the down-counter load.
  function automatic int unsigned clamp1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic is_long(input logic rs,
                                   input logic [7:0] d);
    return !rs && (d[7:2] == 6'd0) && (d != 8'd0);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    logic [7:0] r;
    r = LCD_CMD_FUNC_SET;
    unique case (i)
      2'd0: r = LCD_CMD_FUNC_SET;
      2'd1: r = LCD_CMD_DISP_ON;
      2'd2: r = LCD_CMD_CLEAR;
      2'd3: r = LCD_CMD_ENTRY;
      default: r = LCD_CMD_FUNC_SET;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lcd_ctrl_timer.sv
// Loadable down-counter shared by every timed state of lcd_ctrl.
// Ports: clk/rst_n, load + load_val (cycles-1), done when count is zero.
module lcd_timer #(
  parameter int unsigned   W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only bus controller: valid/ready byte in, RS/DB/EN out.
// Ports: i_clk, i_rst_n, i_wr_vld/rs/data, o_wr_rdy, i_lcd_on,
// o_init_done, o_lcd_data/rs/rw/en/on. Macro: LCD_INIT_SEQ_EN.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP_CYC      = 2,
  parameter int unsigned T_EN_CYC         = 25,
  parameter int unsigned T_HOLD_CYC       = 2,
  parameter int unsigned T_EXEC_SHORT_CYC = 2000,
  parameter int unsigned T_EXEC_LONG_CYC  = 80000,
  parameter int unsigned T_PWRUP_CYC      = 2000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_vld,
  input  logic       i_wr_rs,
  input  logic [7:0] i_wr_data,
  output logic       o_wr_rdy,
  input  logic       i_lcd_on,
  output logic       o_init_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on
);

  localparam int unsigned SET = clamp1(T_SETUP_CYC);
  localparam int unsigned ENC = clamp1(T_EN_CYC);
  localparam int unsigned HLD = clamp1(T_HOLD_CYC);
  localparam int unsigned SHT = clamp1(T_EXEC_SHORT_CYC);
  localparam int unsigned LNG = clamp1(T_EXEC_LONG_CYC);
  localparam int unsigned PWR = clamp1(T_PWRUP_CYC);

  localparam int unsigned M0 = (SET > ENC) ? SET : ENC;
  localparam int unsigned M1 = (M0 > HLD) ? M0 : HLD;
  localparam int unsigned M2 = (M1 > SHT) ? M1 : SHT;
  localparam int unsigned M3 = (M2 > LNG) ? M2 : LNG;
  localparam int unsigned M4 = (M3 > PWR) ? M3 : PWR;
  localparam int unsigned W  = $clog2(M4) + 1;

`ifdef LCD_INIT_SEQ_EN
  localparam lcd_state_e   RST_ST = S_PWRUP;
  localparam logic [W-1:0] T_RST  = W'(PWR - 1);
`else
  localparam lcd_state_e   RST_ST = S_IDLE;
  localparam logic [W-1:0] T_RST  = '0;
`endif

  lcd_state_e   state;
  lcd_state_e   nxt;
  logic         ld;
  logic [W-1:0] ld_val;
  logic         t_done;
  logic         en_q;
  logic         rs_q;
  logic [7:0]   data_q;
  logic         rdy_q;
  logic         on_q;
  logic         accept;

`ifdef LCD_INIT_SEQ_EN
  logic [1:0] idx;
  logic       init_q;
`endif

  assign accept = i_wr_vld && rdy_q;

  lcd_timer #(
    .W       (W),
    .RST_VAL (T_RST)
  ) u_timer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (ld),
    .load_val (ld_val),
    .done     (t_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= RST_ST;
    else          state <= nxt;
  end

  always_comb begin
    nxt    = state;
    ld     = 1'b0;
    ld_val = '0;
    unique case (state)
      S_IDLE: if (accept) begin
        nxt    = S_SETUP;
        ld     = 1'b1;
        ld_val = W'(SET - 1);
      end
      S_SETUP: if (t_done) begin
        nxt    = S_EN_HI;
        ld     = 1'b1;
        ld_val = W'(ENC - 1);
      end
      S_EN_HI: if (t_done) begin
        nxt    = S_HOLD;
        ld     = 1'b1;
        ld_val = W'(HLD - 1);
      end
      S_HOLD: if (t_done) begin
        nxt    = S_WAIT;
        ld     = 1'b1;
        ld_val = is_long(rs_q, data_q) ? W'(LNG - 1)
                                       : W'(SHT - 1);
      end
      S_WAIT: if (t_done) begin
`ifdef LCD_INIT_SEQ_EN
        if (!init_q && idx != 2'(LCD_INIT_LEN - 1))
          nxt = S_INIT_ISSUE;
        else
          nxt = S_IDLE;
`else
        nxt = S_IDLE;
`endif
      end
`ifdef LCD_INIT_SEQ_EN
      S_PWRUP: if (t_done) nxt = S_INIT_ISSUE;
      S_INIT_ISSUE: begin
        nxt    = S_SETUP;
        ld     = 1'b1;
        ld_val = W'(SET - 1);
      end
`endif
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so EN cannot glitch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q   <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      rdy_q  <= 1'b0;
      on_q   <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      idx    <= 2'd0;
      init_q <= 1'b0;
`endif
    end else begin
      en_q  <= (nxt == S_EN_HI);
      rdy_q <= (nxt == S_IDLE);
      on_q  <= i_lcd_on;
      if (state == S_IDLE && accept) begin
        rs_q   <= i_wr_rs;
        data_q <= i_wr_data;
      end
`ifdef LCD_INIT_SEQ_EN
      if (state == S_INIT_ISSUE) begin
        rs_q   <= 1'b0;
        data_q <= init_cmd(idx);
      end
      if (state == S_WAIT && t_done && !init_q) begin
        idx <= idx + 2'd1;
        if (idx == 2'(LCD_INIT_LEN - 1)) init_q <= 1'b1;
      end
`endif
    end
  end

  assign o_wr_rdy   = rdy_q;
  assign o_lcd_en   = en_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_data = data_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_on   = on_q;
`ifdef LCD_INIT_SEQ_EN
  assign o_init_done = init_q;
`else
  assign o_init_done = 1'b1;
`endif

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl with small timing parameters.
// Reference: per-write latency and EN window from the bus timing rules.
module tb_lcd_ctrl;

  localparam int SET   = 2;
  localparam int EN    = 3;
  localparam int HOLD  = 1;
  localparam int SHORT = 5;
  localparam int LONG  = 20;
  localparam int PWR   = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_wr_vld = 1'b0;
  logic       i_wr_rs = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       i_lcd_on = 1'b0;
  logic       o_wr_rdy;
  logic       o_init_done;
  logic [7:0] o_lcd_data;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic       o_lcd_en;
  logic       o_lcd_on;

  int total = 0;
  int bad   = 0;

  logic [7:0] seen[$];
  logic       en_prev = 1'b0;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .T_SETUP_CYC      (SET),
    .T_EN_CYC         (EN),
    .T_HOLD_CYC       (HOLD),
    .T_EXEC_SHORT_CYC (SHORT),
    .T_EXEC_LONG_CYC  (LONG),
    .T_PWRUP_CYC      (PWR)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wr_vld    (i_wr_vld),
    .i_wr_rs     (i_wr_rs),
    .i_wr_data   (i_wr_data),
    .o_wr_rdy    (o_wr_rdy),
    .i_lcd_on    (i_lcd_on),
    .o_init_done (o_init_done),
    .o_lcd_data  (o_lcd_data),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_en    (o_lcd_en),
    .o_lcd_on    (o_lcd_on)
  );

  // Byte on the bus at every EN rising edge.
  always @(negedge clk) begin
    if (o_lcd_en && !en_prev) seen.push_back(o_lcd_data);
    en_prev = o_lcd_en;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (o_wr_rdy === 1'b1) break;
      @(negedge clk);
    end
    chk(tag, o_wr_rdy, 1);
  endtask

  function automatic int exp_lat(input logic rs, input logic [7:0] d);
    int ex;
    ex = (rs == 1'b0 && d >= 8'd1 && d <= 8'd3) ? LONG : SHORT;
    return SET + EN + HOLD + ex;
  endfunction

  // One write, sampled each negedge; k counts edges after accept.
  task automatic do_write(input string tag,
                          input logic rs,
                          input logic [7:0] d);
    int first, enerr, derr, onerr, rwerr;
    logic en_exp;
    wait_rdy({tag, "_rdy"});
    i_wr_vld  = 1'b1;
    i_wr_rs   = rs;
    i_wr_data = d;
    @(posedge clk);
    @(negedge clk);
    i_wr_vld = 1'b0;
    first = -1; enerr = 0; derr = 0; onerr = 0; rwerr = 0;
    for (int k = 0; k < 80; k++) begin
      en_exp = (k >= SET) && (k < SET + EN);
      if (o_lcd_en !== en_exp) enerr++;
      if (o_lcd_data !== d || o_lcd_rs !== rs) derr++;
      if (o_lcd_on !== i_lcd_on) onerr++;
      if (o_lcd_rw !== 1'b0) rwerr++;
      if (o_wr_rdy === 1'b1) begin
        first = k;
        break;
      end
      i_lcd_on = 1'($urandom);
      @(negedge clk);
    end
    chk({tag, "_lat"}, first, exp_lat(rs, d));
    chk({tag, "_en"}, enerr, 0);
    chk({tag, "_data"}, derr, 0);
    chk({tag, "_on"}, onerr, 0);
    chk({tag, "_rw"}, rwerr, 0);
  endtask

  initial begin
    logic       rs;
    logic [7:0] d;
    int         k;

    // Reset values
    #12;
    chk("rst_en", o_lcd_en, 0);
    chk("rst_rdy", o_wr_rdy, 0);
    chk("rst_data", o_lcd_data, 8'h00);
    chk("rst_rs", o_lcd_rs, 0);
    chk("rst_rw", o_lcd_rw, 0);
    chk("rst_on", o_lcd_on, 0);
`ifdef LCD_INIT_SEQ_EN
    chk("rst_init", o_init_done, 0);
`else
    chk("rst_init", o_init_done, 1);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef LCD_INIT_SEQ_EN
    // Power-up wait then four init commands; pre-init write ignored.
    seen.delete();
    i_wr_vld  = 1'b1;
    i_wr_rs   = 1'b1;
    i_wr_data = 8'h55;
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      k++;
      if (o_wr_rdy === 1'b1 || o_init_done === 1'b1) break;
    end
    i_wr_vld = 1'b0;
    chk("init_lat", k, PWR + 4 * (1 + SET + EN + HOLD) + 3 * SHORT + LONG);
    chk("init_done", o_init_done, 1);
    chk("init_rdy", o_wr_rdy, 1);
    chk("init_cnt", seen.size(), 4);
    begin
      logic [7:0] ref_q[4];
      logic [7:0] v;
      ref_q = '{8'h38, 8'h0C, 8'h01, 8'h06};
      for (int i = 0; i < 4; i++) begin
        v = (i < seen.size()) ? seen[i] : 8'hxx;
        chk($sformatf("init_b%0d", i), v, ref_q[i]);
      end
    end
`else
    @(negedge clk);
    chk("rel_rdy", o_wr_rdy, 1);
`endif

    // lcd_on follows one cycle later
    i_lcd_on = 1'b0;
    @(negedge clk);
    i_lcd_on = 1'b1;
    chk("on_old", o_lcd_on, 0);
    @(negedge clk);
    chk("on_new", o_lcd_on, 1);

    // Directed writes
    do_write("data41", 1'b1, 8'h41);
    do_write("clear", 1'b0, 8'h01);
    do_write("dispon", 1'b0, 8'h0C);
    do_write("home", 1'b0, 8'h03);

    // Random writes against the latency model
    for (int n = 0; n < 8; n++) begin
      rs = 1'($urandom);
      if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(1, 3));
      else d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_write($sformatf("rnd%0d", n), rs, d);
    end

    // Back-pressure: valid held across a busy period
    wait_rdy("bp_rdy0");
    seen.delete();
    i_wr_vld  = 1'b1;
    i_wr_rs   = 1'b1;
    i_wr_data = 8'h42;
    @(negedge clk);
    i_wr_data = 8'h43;
    k = 0;
    for (int i = 0; i < 100; i++) begin
      if (o_wr_rdy === 1'b1) break;
      @(negedge clk);
      k++;
    end
    chk("bp_busy", k, exp_lat(1'b1, 8'h42));
    @(negedge clk);
    i_wr_vld = 1'b0;
    wait_rdy("bp_rdy1");
    repeat (2) @(negedge clk);
    chk("bp_cnt", seen.size(), 2);
    chk("bp_b0", (seen.size() > 0) ? seen[0] : 8'hxx, 8'h42);
    chk("bp_b1", (seen.size() > 1) ? seen[1] : 8'hxx, 8'h43);

    // Reset during EN_HI
    wait_rdy("rst_rdy_pre");
    i_wr_vld  = 1'b1;
    i_wr_rs   = 1'b1;
    i_wr_data = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    i_wr_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (o_lcd_en === 1'b1) break;
      @(negedge clk);
    end
    chk("mid_en_hi", o_lcd_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_en", o_lcd_en, 0);
    chk("mid_rdy", o_wr_rdy, 0);
    chk("mid_data", o_lcd_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef LCD_INIT_SEQ_EN
    chk("mid_rel_rdy", o_wr_rdy, 0);
    chk("mid_rel_init", o_init_done, 0);
`else
    chk("mid_rel_rdy", o_wr_rdy, 1);
`endif
    chk("mid_rel_data", o_lcd_data, 8'h00);
    chk("mid_rel_en", o_lcd_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
